// File: rtl/bcd_score_tracker.sv
// Game score tracker: BCD live score with tick divider, level milestones,
// high-score capture on game over, and a registered display mux.
module bcd_score_tracker #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned LEVEL_DIGIT = 2,
    parameter int unsigned LEVEL_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_start,
    input  logic                  game_frozen,
    input  logic                  game_tick,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic [4*DIGITS-1:0]   disp,
    output logic [LEVEL_W-1:0]    level,
    output logic                  milestone_pulse,
    output logic                  new_high
);

    localparam int unsigned SW    = 4 * DIGITS;
    localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SW-1:0]      score_q, score_d;
    logic [SW-1:0]      high_q, high_d;
    logic [SW-1:0]      disp_q, disp_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               ms_q, ms_d;
    logic               nh_q, nh_d;

    logic [SW-1:0]      score_inc;
    logic               all_nines;
    logic               low_nines;

    // Decimal ripple increment; low_nines means the carry reaches LEVEL_DIGIT.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        score_inc = score_q;
        all_nines = 1'b1;
        low_nines = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
                if (i < LEVEL_DIGIT) begin
                    low_nines = 1'b0;
                end
            end
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        score_d = score_q;
        high_d  = high_q;
        level_d = level_q;
        ms_d    = 1'b0;
        nh_d    = nh_q;
        disp_d  = show_high ? high_q : score_q;

        if (game_start) begin
            state_d = S_RUN;
            div_d   = '0;
            score_d = '0;
            level_d = '0;
            nh_d    = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (game_frozen) begin
                        state_d = S_OVER;
                        // Valid BCD orders the same as plain binary.
                        if (score_q > high_q) begin
                            high_d = score_q;
                            nh_d   = 1'b1;
                        end
                    end else if (game_tick) begin
                        if (div_q == DIV_LAST) begin
                            div_d = '0;
                            if (!all_nines) begin
                                score_d = score_inc;
                                ms_d    = low_nines;
                                if (low_nines && (level_q != '1)) begin
                                    level_d = level_q + 1'b1;
                                end
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            score_q <= '0;
            high_q  <= '0;
            disp_q  <= '0;
            level_q <= '0;
            ms_q    <= 1'b0;
            nh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            score_q <= score_d;
            high_q  <= high_d;
            disp_q  <= disp_d;
            level_q <= level_d;
            ms_q    <= ms_d;
            nh_q    <= nh_d;
        end
    end

    assign score           = score_q;
    assign high_score      = high_q;
    assign disp            = disp_q;
    assign level           = level_q;
    assign milestone_pulse = ms_q;
    assign new_high        = nh_q;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Directed bench for bcd_score_tracker: default instance plus a TICK_DIV=3 instance.
module tb_bcd_score_tracker;

    logic        clk = 1'b0;
    logic        rst, game_start, game_frozen, game_tick, show_high;
    logic [15:0] score, high_score, disp;
    logic [2:0]  level;
    logic        milestone_pulse, new_high;

    logic        rst3, game_start3, game_frozen3, game_tick3, show_high3;
    logic [15:0] score3, high_score3, disp3;
    logic [2:0]  level3;
    logic        milestone_pulse3, new_high3;

    int n_checks = 0;
    int n_fail   = 0;
    int ms_cnt;

    always #5 clk = ~clk;

    bcd_score_tracker dut (
        .clk(clk), .rst(rst), .game_start(game_start), .game_frozen(game_frozen),
        .game_tick(game_tick), .show_high(show_high), .score(score),
        .high_score(high_score), .disp(disp), .level(level),
        .milestone_pulse(milestone_pulse), .new_high(new_high)
    );

    bcd_score_tracker #(.TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst3), .game_start(game_start3), .game_frozen(game_frozen3),
        .game_tick(game_tick3), .show_high(show_high3), .score(score3),
        .high_score(high_score3), .disp(disp3), .level(level3),
        .milestone_pulse(milestone_pulse3), .new_high(new_high3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            game_tick = 1'b1;
            step();
        end
        game_tick = 1'b0;
    endtask

    task automatic ticks3(input int n);
        for (int k = 0; k < n; k++) begin
            game_tick3 = 1'b1;
            step();
        end
        game_tick3 = 1'b0;
    endtask

    task automatic start();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_start = 1'b0; game_frozen = 1'b0; game_tick = 1'b0; show_high = 1'b0;
        rst3 = 1'b1; game_start3 = 1'b0; game_frozen3 = 1'b0; game_tick3 = 1'b0; show_high3 = 1'b0;
        step();
        step();
        check_eq("rst_score", score, 16'h0000);
        check_eq("rst_high", high_score, 16'h0000);
        check_eq("rst_disp", disp, 16'h0000);
        check_eq("rst_level", level, 3'd0);
        check_eq("rst_ms", milestone_pulse, 1'b0);
        check_eq("rst_nh", new_high, 1'b0);
        check_eq("rst_score3", score3, 16'h0000);
        rst = 1'b0;
        rst3 = 1'b0;

        // Decimal counting and first milestone
        start();
        check_eq("start_score", score, 16'h0000);
        ticks(99);
        check_eq("t99_score", score, 16'h0099);
        check_eq("t99_level", level, 3'd0);
        check_eq("t99_ms", milestone_pulse, 1'b0);
        ticks(1);
        check_eq("t100_score", score, 16'h0100);
        check_eq("t100_ms", milestone_pulse, 1'b1);
        check_eq("t100_level", level, 3'd1);
        step();
        check_eq("t100_ms_off", milestone_pulse, 1'b0);

        // Restart from RUN clears score and level
        start();
        check_eq("restart_score", score, 16'h0000);
        check_eq("restart_level", level, 3'd0);

        // High score capture, then equal score does not set new_high
        ticks(42);
        check_eq("s42_score", score, 16'h0042);
        game_frozen = 1'b1;
        step();
        check_eq("over1_high", high_score, 16'h0042);
        check_eq("over1_nh", new_high, 1'b1);
        ticks(3);
        check_eq("over_tick_ign", score, 16'h0042);
        game_frozen = 1'b0;
        start();
        check_eq("restart_nh_clr", new_high, 1'b0);
        check_eq("restart_high_hold", high_score, 16'h0042);
        ticks(42);
        game_frozen = 1'b1;
        step();
        check_eq("over2_high", high_score, 16'h0042);
        check_eq("over2_nh_eq", new_high, 1'b0);
        game_frozen = 1'b0;

        // Reach 300 for the display test, three milestones
        start();
        ticks(300);
        check_eq("s300_level", level, 3'd3);
        game_frozen = 1'b1;
        step();
        check_eq("over3_high", high_score, 16'h0300);
        check_eq("over3_nh", new_high, 1'b1);
        game_frozen = 1'b0;

        start();
        ticks(15);
        for (int i = 0; i < 6; i++) begin
            show_high = (i % 2) == 1;
            step();
            check_eq("disp_toggle", disp, show_high ? 16'h0300 : 16'h0015);
        end
        show_high = 1'b0;
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        check_eq("lag_score", score, 16'h0016);
        check_eq("lag_disp_old", disp, 16'h0015);
        step();
        check_eq("lag_disp_new", disp, 16'h0016);

        // Reset mid-run overrides game_start and discards the run
        start();
        ticks(57);
        check_eq("s57_score", score, 16'h0057);
        rst = 1'b1;
        game_start = 1'b1;
        step();
        check_eq("mrst_score", score, 16'h0000);
        check_eq("mrst_high", high_score, 16'h0000);
        check_eq("mrst_disp", disp, 16'h0000);
        check_eq("mrst_level", level, 3'd0);
        check_eq("mrst_nh", new_high, 1'b0);
        rst = 1'b0;
        game_start = 1'b0;
        ticks(5);
        check_eq("idle_tick_ign", score, 16'h0000);

        // Saturation at 9999 and level clamp
        start();
        ms_cnt = 0;
        for (int k = 0; k < 9999; k++) begin
            game_tick = 1'b1;
            step();
            if (milestone_pulse) ms_cnt++;
        end
        check_eq("sat_score", score, 16'h9999);
        check_eq("sat_ms_count", ms_cnt, 99);
        check_eq("sat_level", level, 3'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("sat_extra_ms", milestone_pulse, 1'b0);
        end
        game_tick = 1'b0;
        check_eq("sat_extra_score", score, 16'h9999);
        game_frozen = 1'b1;
        step();
        check_eq("sat_high", high_score, 16'h9999);
        check_eq("sat_nh", new_high, 1'b1);

        // Start while frozen: RUN then OVER, zero score must not beat high
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        check_eq("fz_start_nh", new_high, 1'b0);
        check_eq("fz_start_score", score, 16'h0000);
        step();
        check_eq("fz_over_high", high_score, 16'h9999);
        check_eq("fz_over_nh", new_high, 1'b0);
        game_frozen = 1'b0;

        // TICK_DIV=3 instance
        game_start3 = 1'b1;
        step();
        game_start3 = 1'b0;
        ticks3(7);
        check_eq("div3_7ticks", score3, 16'h0002);
        game_start3 = 1'b1;
        game_tick3  = 1'b1;
        step();
        game_start3 = 1'b0;
        game_tick3  = 1'b0;
        check_eq("div3_start_prio", score3, 16'h0000);
        ticks3(2);
        check_eq("div3_cleared", score3, 16'h0000);
        ticks3(1);
        check_eq("div3_third", score3, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_score_tracker.md
BCD_SCORE_TRACKER -- requirements
Module: bcd_score_tracker

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD score digits (1..8).
REQ-002 Parameter TICK_DIV, default 1: qualifying game ticks per score increment (1..255).
REQ-003 Parameter LEVEL_DIGIT, default 2: digit index whose carry-in marks a milestone (0 < LEVEL_DIGIT < DIGITS).
REQ-004 Parameter LEVEL_W, default 3: level output width. Level saturates at 2^LEVEL_W-1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 game_start  in  1  one-cycle pulse; begins or restarts a run.
REQ-008 game_frozen  in  1  level; high = game over or paused by player logic.
REQ-009 game_tick  in  1  one-cycle pulse at game rate.
REQ-010 show_high  in  1  display select; 1 = high score, 0 = live score.
REQ-011 score  out  4*DIGITS  live BCD score, digit 0 in bits [3:0].
REQ-012 high_score  out  4*DIGITS  best BCD score since reset.
REQ-013 disp  out  4*DIGITS  registered display value.
REQ-014 level  out  LEVEL_W  speed level for obstacle logic.
REQ-015 milestone_pulse  out  1  one-cycle pulse per milestone (audio).
REQ-016 new_high  out  1  level; set when last run beat high_score.

Function
REQ-017 States SHALL be IDLE, RUN, OVER; a tick-divider counter of width ceil(log2(TICK_DIV+1)) SHALL be kept.
REQ-018 IDLE/OVER + game_start -> RUN next cycle; score, level, divider cleared, new_high cleared.
REQ-019 RUN + game_start -> stay RUN, same clears as REQ-018 (restart).
REQ-020 game_start SHALL take priority over game_tick in the same cycle; no increment that cycle.
REQ-021 In RUN, a game_tick with game_frozen=0 is qualifying; divider increments; at TICK_DIV-1 divider wraps to 0 and score increments by 1.
REQ-022 Score update SHALL appear on score one cycle after the qualifying tick.
REQ-023 Increment SHALL be decimal: digit 9 -> 0 with carry to next digit; no digit ever holds A..F.
REQ-024 Score all-9s SHALL saturate: further increments leave score unchanged, no milestone.
REQ-025 milestone_pulse SHALL assert for exactly one cycle, coincident with the score update, when the increment carries into digit LEVEL_DIGIT (digits below it all wrap to 0).
REQ-026 On each milestone level SHALL increment by 1, saturating at 2^LEVEL_W-1; milestone_pulse still fires when saturated.
REQ-027 In RUN, game_frozen=1 with game_start=0 -> OVER next cycle; divider holds; non-qualifying ticks ignored.
REQ-028 On RUN->OVER, if score > high_score (numeric BCD compare) high_score <= score and new_high <= 1 in the same edge; equal score SHALL NOT set new_high.
REQ-029 In OVER and IDLE score, level, high_score SHALL hold; game_tick ignored.
REQ-030 disp SHALL equal (show_high ? high_score : score) sampled one cycle earlier (1-cycle latency).
REQ-031 game_frozen held high at game_start: enter RUN, then OVER the following cycle per REQ-027.

Reset
REQ-032 rst=1 SHALL force IDLE; score, high_score, disp, level, divider = 0; milestone_pulse, new_high = 0.
REQ-033 rst SHALL override all other inputs including game_start in the same cycle; reset mid-run discards high-score update.

Verification
REQ-034 DIGITS=4,TICK_DIV=1: reset, start, 99 ticks -> score=0x0099, level=0; 100th tick -> score=0x0100, milestone_pulse one cycle, level=1.
REQ-035 TICK_DIV=3: start, 7 ticks -> score=0x0002; tick coincident with game_start -> score stays 0x0000.
REQ-036 Run to 0x0042, freeze -> OVER, high_score=0x0042, new_high=1; restart, run to 0x0042, freeze -> high unchanged, new_high=0.
REQ-037 Preload via 9999 ticks -> score=0x9999; extra ticks -> 0x9999, no milestone; LEVEL_W=3 level saturates at 7.
REQ-038 show_high toggled each cycle with score=0x0015, high=0x0300 -> disp follows with exactly 1-cycle lag.
REQ-039 rst asserted mid-run at score 0x0057 -> next cycle all outputs 0, state IDLE, ticks ignored until game_start.
